// File: rtl/cam_pkg.sv
// Shared definitions for the frame capture path:
// state encoding, pixel width and default image geometry.
package cam_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE    = 2'd0;
   localparam state_t S_ARM     = 2'd1;
   localparam state_t S_CAPTURE = 2'd2;
   localparam state_t S_DONE    = 2'd3;

   localparam int PIX_W     = 8;
   localparam int DEF_IMG_W = 64;
   localparam int DEF_IMG_H = 48;

endpackage

// File: rtl/cap_timeout_timer.sv
// Watchdog for the ARM state: counts enabled cycles after a clear
// and flags expiry once the counter reaches its all-ones value.
module cap_timeout_timer #(
   parameter int W = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [W-1:0] cnt;

   assign expired = &cnt;

   // Count up while enabled, holding at the terminal value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Single-frame grab sequencer: arms on start, writes each valid pixel
// of one frame into the buffer and reports count and error status.
module frame_capture_ctrl
   import cam_pkg::*;
#(
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IMG_H     = DEF_IMG_H,
   parameter int ADDR_W    = 12,
   parameter int TIMEOUT_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [PIX_W-1:0]  pixel_in,
   input  logic              pixel_valid,
   input  logic              frame_start,
   input  logic              frame_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   pix_count,
   output logic              err_short,
   output logic              err_long,
   output logic              err_timeout
);

   localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(IMG_W * IMG_H);

   state_t state;
   state_t state_nx;
   logic   tmr_clear;
   logic   tmr_en;
   logic   expired;

   cap_timeout_timer #(
      .W(TIMEOUT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .expired(expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; abort has priority over frame events.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = S_ARM;
         end
         S_ARM: begin
            if (abort)            state_nx = S_IDLE;
            else if (frame_start) state_nx = S_CAPTURE;
            else if (expired)     state_nx = S_IDLE;
         end
         S_CAPTURE: begin
            if (abort)           state_nx = S_IDLE;
            else if (frame_done) state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State-decoded controls: busy flag and watchdog clear/enable.
   always_comb begin
      busy      = 1'b0;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      unique case (state)
         S_IDLE:    tmr_clear = 1'b1;
         S_ARM: begin
            busy   = 1'b1;
            tmr_en = 1'b1;
         end
         S_CAPTURE: busy = 1'b1;
         S_DONE:    ;
         default:   ;
      endcase
   end

   // Pixel counter, registered write port and sticky status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         done        <= 1'b0;
         pix_count   <= '0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  pix_count   <= '0;
                  err_short   <= 1'b0;
                  err_long    <= 1'b0;
                  err_timeout <= 1'b0;
               end
            end
            S_ARM: begin
               if (!abort && !frame_start && expired) begin
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (!abort) begin
                  if (frame_start && !frame_done) begin
                     pix_count <= '0;
                  end else if (pixel_valid) begin
                     if (pix_count < NPIX) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pix_count[ADDR_W-1:0];
                        wr_data <= pixel_in;
                     end
                     if (pix_count != '1) pix_count <= pix_count + 1'b1;
                  end
               end
            end
            S_DONE: begin
               done      <= 1'b1;
               err_short <= (pix_count < NPIX);
               err_long  <= (pix_count > NPIX);
            end
            default: ;
         endcase
      end
   end

endmodule
